// File: rtl/bp_cce_hybrid_mode_ctrl.sv
// Hybrid CCE operating-mode sequencer: stalls, drains and switches between uncached and normal mode.
// Optional drain timeout is enabled by defining BP_CCE_MODE_CTRL_TIMEOUT_EN.

package bp_cce_mode_pkg;
    typedef enum logic {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;
endpackage

module bp_cce_hybrid_mode_ctrl
    import bp_cce_mode_pkg::*;
#(
    parameter int unsigned  num_drain_p     = 3,
    parameter int unsigned  pending_width_p = 4,
    parameter int unsigned  timeout_width_p = 16,
    parameter bp_cce_mode_e reset_mode_p    = e_cce_mode_uncached
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  bp_cce_mode_e               mode_req_i,
    input  logic                       mode_req_v_i,
    output logic                       mode_req_ready_and_o,
    output logic                       mode_done_v_o,
    output logic                       mode_done_err_o,
    input  logic                       mode_done_yumi_i,
    output bp_cce_mode_e               cce_mode_o,
    output logic                       stall_o,
    input  logic [num_drain_p-1:0]     empty_i,
    input  logic                       mem_cmd_sent_i,
    input  logic                       mem_resp_recv_i,
    output logic [pending_width_p-1:0] pending_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {
        e_ready,
        e_drain,
        e_switch,
        e_done
    } state_e;

    state_e                     state_q, state_d;
    bp_cce_mode_e               target_q;
    bp_cce_mode_e               mode_q;
    logic [pending_width_p-1:0] pending_q;
    logic                       accept;
    logic                       drain_ok;
    logic                       timeout_hit;
    logic                       pending_inc, pending_dec;

    assign accept   = (state_q == e_ready) && mode_req_v_i;
    assign drain_ok = (&empty_i) && (pending_q == '0);

`ifdef BP_CCE_MODE_CTRL_TIMEOUT_EN
    logic [timeout_width_p-1:0] drain_cnt_q;
    logic                       err_q;

    assign timeout_hit = (state_q == e_drain) && !drain_ok && (drain_cnt_q == '1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (state_q != e_drain)
                drain_cnt_q <= '0;
            else
                drain_cnt_q <= drain_cnt_q + 1'b1;
            if (accept)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign mode_done_err_o = err_q;
`else
    assign timeout_hit     = 1'b0;
    assign mode_done_err_o = 1'b0;
`endif

    // NOTE: every output of this block is assigned a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_ready:  if (mode_req_v_i) state_d = (mode_req_i == mode_q) ? e_done : e_drain;
            e_drain:  if (drain_ok) state_d = e_switch;
                      else if (timeout_hit) state_d = e_done;
            e_switch: state_d = e_done;
            e_done:   if (mode_done_yumi_i) state_d = e_ready;
            default:  state_d = e_ready;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_ready;
            target_q <= reset_mode_p;
            mode_q   <= reset_mode_p;
        end else begin
            state_q <= state_d;
            if (accept)
                target_q <= mode_req_i;
            if (state_q == e_switch)
                mode_q <= target_q;
        end
    end

    // Saturating outstanding-command counter; out-of-range events hold the value.
    assign pending_inc = mem_cmd_sent_i && !mem_resp_recv_i && (pending_q != '1);
    assign pending_dec = mem_resp_recv_i && !mem_cmd_sent_i && (pending_q != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            pending_q <= '0;
        else if (pending_inc)
            pending_q <= pending_q + 1'b1;
        else if (pending_dec)
            pending_q <= pending_q - 1'b1;
    end

    assign mode_req_ready_and_o = (state_q == e_ready);
    assign mode_done_v_o        = (state_q == e_done);
    assign stall_o              = (state_q == e_drain) || (state_q == e_switch);
    assign busy_o               = (state_q != e_ready);
    assign cce_mode_o           = mode_q;
    assign pending_o            = pending_q;

    param_a: assert property (@(posedge clk_i) (timeout_width_p >= 1) && (pending_width_p >= 1));

    overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(mem_cmd_sent_i && !mem_resp_recv_i && (pending_q == '1)));

    underflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(mem_resp_recv_i && !mem_cmd_sent_i && (pending_q == '0)));

    // Units must stay empty once the switch decision has been taken.
    switch_empty_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q == e_switch) |-> (&empty_i));

endmodule

// File: tb/tb_bp_cce_hybrid_mode_ctrl.sv
// Directed self-checking bench for bp_cce_hybrid_mode_ctrl (default build, timeout disabled).
module tb_bp_cce_hybrid_mode_ctrl;
    import bp_cce_mode_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    bp_cce_mode_e mode_req_i;
    logic         mode_req_v_i;
    logic         mode_req_ready_and_o;
    logic         mode_done_v_o;
    logic         mode_done_err_o;
    logic         mode_done_yumi_i;
    bp_cce_mode_e cce_mode_o;
    logic         stall_o;
    logic [2:0]   empty_i;
    logic         mem_cmd_sent_i;
    logic         mem_resp_recv_i;
    logic [3:0]   pending_o;
    logic         busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    bp_cce_hybrid_mode_ctrl dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .mode_req_i           (mode_req_i),
        .mode_req_v_i         (mode_req_v_i),
        .mode_req_ready_and_o (mode_req_ready_and_o),
        .mode_done_v_o        (mode_done_v_o),
        .mode_done_err_o      (mode_done_err_o),
        .mode_done_yumi_i     (mode_done_yumi_i),
        .cce_mode_o           (cce_mode_o),
        .stall_o              (stall_o),
        .empty_i              (empty_i),
        .mem_cmd_sent_i       (mem_cmd_sent_i),
        .mem_resp_recv_i      (mem_resp_recv_i),
        .pending_o            (pending_o),
        .busy_o               (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; inputs and outputs are handled 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic consume_done();
        mode_done_yumi_i = 1'b1;
        tick();
        mode_done_yumi_i = 1'b0;
    endtask

    initial begin
        reset_n_i        = 1'b0;
        mode_req_i       = e_cce_mode_uncached;
        mode_req_v_i     = 1'b0;
        mode_done_yumi_i = 1'b0;
        empty_i          = 3'b111;
        mem_cmd_sent_i   = 1'b0;
        mem_resp_recv_i  = 1'b0;
        #12;
        check("rst_mode",    32'(cce_mode_o), 32'(e_cce_mode_uncached));
        check("rst_stall",   32'(stall_o), 0);
        check("rst_done_v",  32'(mode_done_v_o), 0);
        check("rst_err",     32'(mode_done_err_o), 0);
        check("rst_busy",    32'(busy_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        check("rst_ready",   32'(mode_req_ready_and_o), 1);
        reset_n_i = 1'b1;
        tick();

        // Same-mode request: completion one cycle after accept, no stall.
        mode_req_i   = e_cce_mode_uncached;
        mode_req_v_i = 1'b1;
        tick();
        mode_req_v_i = 1'b0;
        check("same_done_v", 32'(mode_done_v_o), 1);
        check("same_stall",  32'(stall_o), 0);
        check("same_mode",   32'(cce_mode_o), 32'(e_cce_mode_uncached));
        check("same_ready",  32'(mode_req_ready_and_o), 0);
        consume_done();
        check("same_idle",   32'(busy_o), 0);

        // Empty system: stall t+1..t+2, mode change and completion at t+3.
        mode_req_i   = e_cce_mode_normal;
        mode_req_v_i = 1'b1;
        tick();
        mode_req_v_i = 1'b0;
        check("sw_t1_stall", 32'(stall_o), 1);
        check("sw_t1_mode",  32'(cce_mode_o), 32'(e_cce_mode_uncached));
        check("sw_t1_ready", 32'(mode_req_ready_and_o), 0);
        tick();
        check("sw_t2_stall", 32'(stall_o), 1);
        check("sw_t2_mode",  32'(cce_mode_o), 32'(e_cce_mode_uncached));
        check("sw_t2_done",  32'(mode_done_v_o), 0);
        tick();
        check("sw_t3_mode",  32'(cce_mode_o), 32'(e_cce_mode_normal));
        check("sw_t3_done",  32'(mode_done_v_o), 1);
        check("sw_t3_err",   32'(mode_done_err_o), 0);
        check("sw_t3_stall", 32'(stall_o), 0);
        ticks(2);
        check("sw_hold_done", 32'(mode_done_v_o), 1);
        consume_done();
        check("sw_idle", 32'(busy_o), 0);

        // Outstanding commands block the drain until all responses return.
        mem_cmd_sent_i = 1'b1;
        ticks(3);
        mem_cmd_sent_i = 1'b0;
        check("pend_3", 32'(pending_o), 3);
        mode_req_i   = e_cce_mode_uncached;
        mode_req_v_i = 1'b1;
        tick();
        mode_req_v_i = 1'b0;
        ticks(4);
        check("pend_wait_stall", 32'(stall_o), 1);
        check("pend_wait_done",  32'(mode_done_v_o), 0);
        mem_resp_recv_i = 1'b1;
        ticks(3);
        mem_resp_recv_i = 1'b0;
        check("pend_zero",      32'(pending_o), 0);
        check("pend_zero_mode", 32'(cce_mode_o), 32'(e_cce_mode_normal));
        check("pend_zero_done", 32'(mode_done_v_o), 0);
        tick();
        check("pend_sw_stall",  32'(stall_o), 1);
        check("pend_sw_mode",   32'(cce_mode_o), 32'(e_cce_mode_normal));
        tick();
        check("pend_done_v",    32'(mode_done_v_o), 1);
        check("pend_done_mode", 32'(cce_mode_o), 32'(e_cce_mode_uncached));
        consume_done();

        // One unit not empty keeps the drain waiting.
        empty_i      = 3'b101;
        mode_req_i   = e_cce_mode_normal;
        mode_req_v_i = 1'b1;
        tick();
        mode_req_v_i = 1'b0;
        ticks(3);
        check("empty_wait_stall", 32'(stall_o), 1);
        check("empty_wait_done",  32'(mode_done_v_o), 0);
        empty_i = 3'b111;
        tick();
        check("empty_sw_mode", 32'(cce_mode_o), 32'(e_cce_mode_uncached));
        tick();
        check("empty_done_v",  32'(mode_done_v_o), 1);
        check("empty_mode",    32'(cce_mode_o), 32'(e_cce_mode_normal));
        consume_done();

        // Counter arithmetic: simultaneous events cancel, fill to max.
        mem_cmd_sent_i = 1'b1;
        ticks(2);
        mem_resp_recv_i = 1'b1;
        tick();
        check("pend_both", 32'(pending_o), 2);
        mem_cmd_sent_i = 1'b0;
        ticks(2);
        mem_resp_recv_i = 1'b0;
        check("pend_back0", 32'(pending_o), 0);
        mem_cmd_sent_i = 1'b1;
        ticks(15);
        mem_cmd_sent_i = 1'b0;
        check("pend_max", 32'(pending_o), 15);
        mem_resp_recv_i = 1'b1;
        ticks(15);
        mem_resp_recv_i = 1'b0;
        check("pend_drained", 32'(pending_o), 0);

        // Reset during drain aborts without a completion.
        mem_cmd_sent_i = 1'b1;
        tick();
        mem_cmd_sent_i = 1'b0;
        empty_i      = 3'b000;
        mode_req_i   = e_cce_mode_uncached;
        mode_req_v_i = 1'b1;
        tick();
        mode_req_v_i = 1'b0;
        tick();
        check("abort_pre_stall", 32'(stall_o), 1);
        reset_n_i = 1'b0;
        #1;
        check("abort_stall",   32'(stall_o), 0);
        check("abort_mode",    32'(cce_mode_o), 32'(e_cce_mode_uncached));
        check("abort_busy",    32'(busy_o), 0);
        check("abort_pending", 32'(pending_o), 0);
        check("abort_done_v",  32'(mode_done_v_o), 0);
        #5;
        reset_n_i = 1'b1;
        empty_i   = 3'b111;
        ticks(3);
        check("abort_after_done_v", 32'(mode_done_v_o), 0);
        mode_req_i   = e_cce_mode_normal;
        mode_req_v_i = 1'b1;
        check("abort_ready", 32'(mode_req_ready_and_o), 1);
        tick();
        mode_req_v_i = 1'b0;
        ticks(2);
        check("abort_re_done", 32'(mode_done_v_o), 1);
        check("abort_re_mode", 32'(cce_mode_o), 32'(e_cce_mode_normal));
        consume_done();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bp_cce_hybrid_mode_ctrl.md
Name: bp_cce_hybrid_mode_ctrl

Overview:
- Sequences CCE operating-mode transitions (uncached-only <-> normal) for the hybrid CCE.
- Accepts mode-change requests from the CCE config path, then drives stall to the request splitter and downstream pipes.
- Drains them by waiting on their empty indications and on a count of outstanding memory commands.
- Updates the registered cce_mode output only while everything is quiesced, then returns a completion response.

Parameters:
- num_drain_p, 3, number of empty indications that must all be high before switching (splitter, cached pipe, uncached pipe).
- pending_width_p, 4, width of outstanding memory command counter; max 2^pending_width_p-1 outstanding.
- timeout_width_p, 16, width of drain cycle counter (used only with optional feature).
- reset_mode_p, e_cce_mode_uncached, cce_mode_o value out of reset.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mode_req_i  in  $bits(bp_cce_mode_e)  requested mode
- mode_req_v_i  in  1  request valid
- mode_req_ready_and_o  out  1  request ready (ready&valid)
- mode_done_v_o  out  1  completion valid
- mode_done_err_o  out  1  completion error flag (timeout abort)
- mode_done_yumi_i  in  1  completion consumed
- cce_mode_o  out  $bits(bp_cce_mode_e)  current CCE mode, registered
- stall_o  out  1  stall to splitter/pipes
- empty_i  in  num_drain_p  per-unit empty indications
- mem_cmd_sent_i  in  1  one memory command handshake completed this cycle
- mem_resp_recv_i  in  1  one memory response consumed this cycle
- pending_o  out  pending_width_p  outstanding memory command count
- busy_o  out  1  FSM not in e_ready

Behaviour:
- Reset (async assert, sync release):
  - state=e_ready, cce_mode_o=reset_mode_p, pending_o=0, stall_o=0, mode_done_v_o=0, mode_done_err_o=0, busy_o=0.
  - Reset mid-transition aborts with no completion issued.
- FSM states: e_ready, e_drain, e_switch, e_done.
- e_ready:
  - mode_req_ready_and_o=1; stall_o=0.
  - On mode_req_v_i, latch mode_req_i into target register.
  - If target == cce_mode_o, go directly to e_done with err=0 and no stall.
  - Otherwise go to e_drain.
- e_drain:
  - stall_o=1.
  - When &empty_i & (pending_o==0) in the same cycle, go to e_switch. The earliest exit is the first cycle of e_drain.
- e_switch:
  - stall_o=1 for exactly one cycle.
  - cce_mode_o <= target on exit; go to e_done.
- e_done:
  - stall_o=0; mode_done_v_o=1 until mode_done_yumi_i, then e_ready.
  - mode_done_err_o is valid with mode_done_v_o.
  - mode_req_ready_and_o=0 in every state except e_ready.
- Latency for a mode change with the system already empty:
  - accept at cycle t; e_drain at t+1; e_switch at t+2.
  - cce_mode_o changes and mode_done_v_o rises at t+3.
- Same-mode request: mode_done_v_o at t+1; stall_o never asserted.
- stall_o and cce_mode_o are decoded from or held in registers only; no combinational path from any input.
- cce_mode_o never changes outside the e_switch->e_done edge.
- Pending counter (runs in all states):
  - +1 on mem_cmd_sent_i; -1 on mem_resp_recv_i; both in the same cycle -> unchanged.
  - Overflow (increment at max) and underflow (decrement at 0) hold the value and fire simulation-only assertions.
- empty_i is sampled only in e_drain. Deassertion of empty_i after the exit decision is a protocol error; an assertion checks all empty_i during e_switch.

Optional Feature:
- Macro BP_CCE_MODE_CTRL_TIMEOUT_EN, defined:
  - A timeout_width_p counter clears on entry to e_drain and increments each e_drain cycle.
  - If it reaches all-ones before the drain condition, go to e_done with mode_done_err_o=1; cce_mode_o is unchanged and stall_o drops.
  - The drain condition wins if both occur in the same cycle.
- Not defined:
  - No counter is instantiated; e_drain waits indefinitely.
  - mode_done_err_o is tied to 0.

Test Plan:
- Reset, then request e_cce_mode_normal with all empty_i=3'b111 and pending=0 -> stall_o high cycles t+1..t+2, cce_mode_o=normal at t+3, mode_done_v_o=1, err=0.
- Request uncached while already uncached -> mode_done_v_o at t+1, stall_o never high, cce_mode_o unchanged.
- 3 mem_cmd_sent_i pulses, then request normal with empty_i=3'b111 -> remains in e_drain until 3 mem_resp_recv_i pulses. Switch occurs the cycle after pending_o reaches 0.
- Simultaneous mem_cmd_sent_i and mem_resp_recv_i with pending_o=2 -> pending_o stays 2. 15 sends at pending_width_p=4 -> pending_o=15 and the 16th send fires the overflow assertion.
- With BP_CCE_MODE_CTRL_TIMEOUT_EN, timeout_width_p=4, and empty_i[1] held 0 -> mode_done_err_o=1 after 15 drain cycles, cce_mode_o unchanged, stall_o=0.
- Assert reset_n_i low while in e_drain -> outputs immediately return to reset values, no mode_done_v_o; the next request is accepted normally.
